// File: rtl/bus_mem_if_pkg.sv
// ---------------------------------------------------------------------------
// bus_mem_if_pkg
// Shared definitions for the bus-to-SRAM interface block:
//   - WORD_W / DEFAULT_WAIT_CYCLES : default word width and strobe wait count
//   - mem_state_e                  : access sequencer states
//   - sram_strobes_t               : bundle of the five active-low SRAM strobes
//   - cnt_width()                  : width of a down-counter for a wait count
//   - access_strobes()             : strobe pattern for an active access
// ---------------------------------------------------------------------------
package bus_mem_if_pkg;

    localparam int WORD_W              = 16;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic ce_n;
        logic ub_n;
        logic lb_n;
        logic oe_n;
        logic we_n;
    } sram_strobes_t;

    localparam sram_strobes_t STROBES_IDLE = '{ce_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1,
                                               oe_n: 1'b1, we_n: 1'b1};

    // Counter must hold WAIT_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Chip and both byte lanes enabled; exactly one of OE_N / WE_N active.
    function automatic sram_strobes_t access_strobes(input logic is_write);
        sram_strobes_t s;
        s.ce_n = 1'b0;
        s.ub_n = 1'b0;
        s.lb_n = 1'b0;
        s.oe_n = is_write;
        s.we_n = ~is_write;
        return s;
    endfunction

endpackage

// File: rtl/bus_mem_if_wait_counter.sv
// ---------------------------------------------------------------------------
// mem_wait_counter
// Loadable down-counter used to time memory strobes. Saturates at zero.
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high clear
//   i_load  : load i_init (has priority over i_en)
//   i_en    : decrement by one while non-zero
//   i_init  : load value
//   o_zero  : count is zero
// ---------------------------------------------------------------------------
module mem_wait_counter #(
    parameter int CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_init,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_init;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/bus_mem_if.sv
// ---------------------------------------------------------------------------
// bus_mem_if
// Receiving end of the datapath bus. Captures the bus into MAR/MDR and runs
// single-word SRAM accesses with strobes held for WAIT_CYCLES cycles.
//   Clk, Reset           : clock; synchronous active-high reset
//   BUS                  : datapath bus value
//   LD_MAR / LD_MDR      : load MAR / MDR from BUS (honoured only when idle)
//   mem_start, mem_we    : start one access; mem_we=1 write, 0 read
//   Data_from_SRAM       : SRAM read data, captured into MDR at end of a read
//   MAR, MDR             : address / data registers
//   ADDR, Data_to_SRAM   : SRAM address / write data (copies of MAR / MDR)
//   CE_N..WE_N           : registered active-low SRAM strobes
//   busy, done           : registered status; done pulses for one cycle
// ---------------------------------------------------------------------------
module bus_mem_if
    import bus_mem_if_pkg::*;
#(
    parameter int WIDTH       = WORD_W,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] BUS,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             mem_start,
    input  logic             mem_we,
    input  logic [WIDTH-1:0] Data_from_SRAM,
    output logic [WIDTH-1:0] MAR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] ADDR,
    output logic [WIDTH-1:0] Data_to_SRAM,
    output logic             CE_N,
    output logic             UB_N,
    output logic             LB_N,
    output logic             OE_N,
    output logic             WE_N,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    mem_state_e    r_state;
    logic          r_op_we;
    logic [WIDTH-1:0] r_mar;
    logic [WIDTH-1:0] r_mdr;
    sram_strobes_t r_strobes;
    logic          r_busy;
    logic          r_done;

    logic w_idle;
    logic w_accept;
    logic w_cnt_zero;
    logic w_last_access;

    assign w_idle        = (r_state == IDLE);
    assign w_accept      = w_idle && mem_start;
    // Final ACCESS cycle: the edge that ends it moves to DONE.
    assign w_last_access = (r_state == ACCESS) && w_cnt_zero;

    mem_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .i_clk   (Clk),
        .i_reset (Reset),
        .i_load  (w_accept),
        .i_en    (r_state == ACCESS),
        .i_init  (CNT_INIT),
        .o_zero  (w_cnt_zero)
    );

    // MAR/MDR. Loads are only honoured in IDLE so both stay stable across an
    // access; a load coinciding with mem_start lands on the same edge, so the
    // access sees the new value. Read capture outranks LD_MDR.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mar <= '0;
            r_mdr <= '0;
        end else begin
            if (w_idle && LD_MAR) begin
                r_mar <= BUS;
            end
            if (w_last_access && !r_op_we) begin
                r_mdr <= Data_from_SRAM;
            end else if (w_idle && LD_MDR) begin
                r_mdr <= BUS;
            end
        end
    end

    // Sequencer. Outputs are set on the transition into each state, so the
    // strobes/busy/done registers line up exactly with the state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_op_we   <= 1'b0;
            r_strobes <= STROBES_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (mem_start) begin
                        r_op_we   <= mem_we;
                        r_strobes <= access_strobes(mem_we);
                        r_busy    <= 1'b1;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_cnt_zero) begin
                        r_strobes <= STROBES_IDLE;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_strobes <= STROBES_IDLE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign MAR          = r_mar;
    assign MDR          = r_mdr;
    assign ADDR         = r_mar;
    assign Data_to_SRAM = r_mdr;
    assign CE_N         = r_strobes.ce_n;
    assign UB_N         = r_strobes.ub_n;
    assign LB_N         = r_strobes.lb_n;
    assign OE_N         = r_strobes.oe_n;
    assign WE_N         = r_strobes.we_n;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_bus_mem_if.sv
// ---------------------------------------------------------------------------
// tb_bus_mem_if
// Two instances share one stimulus stream: dut_a with WAIT_CYCLES=2 and
// dut_b with WAIT_CYCLES=1. A timing model (cycles elapsed since an accepted
// mem_start) predicts every output of both instances each cycle; directed
// literal checks pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_bus_mem_if;

    localparam int W  = 16;
    localparam int WA = 2;
    localparam int WB = 1;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [W-1:0] BUS;
    logic         LD_MAR;
    logic         LD_MDR;
    logic         mem_start;
    logic         mem_we;
    logic [W-1:0] Data_from_SRAM;

    logic [W-1:0] mar_a, mdr_a, addr_a, dts_a;
    logic         ce_n_a, ub_n_a, lb_n_a, oe_n_a, we_n_a, busy_a, done_a;
    logic [W-1:0] mar_b, mdr_b, addr_b, dts_b;
    logic         ce_n_b, ub_n_b, lb_n_b, oe_n_b, we_n_b, busy_b, done_b;

    always #5 Clk = ~Clk;

    bus_mem_if #(.WIDTH(W), .WAIT_CYCLES(WA)) u_dut_a (
        .Clk(Clk), .Reset(Reset), .BUS(BUS), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .mem_start(mem_start), .mem_we(mem_we), .Data_from_SRAM(Data_from_SRAM),
        .MAR(mar_a), .MDR(mdr_a), .ADDR(addr_a), .Data_to_SRAM(dts_a),
        .CE_N(ce_n_a), .UB_N(ub_n_a), .LB_N(lb_n_a), .OE_N(oe_n_a), .WE_N(we_n_a),
        .busy(busy_a), .done(done_a)
    );

    bus_mem_if #(.WIDTH(W), .WAIT_CYCLES(WB)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .BUS(BUS), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .mem_start(mem_start), .mem_we(mem_we), .Data_from_SRAM(Data_from_SRAM),
        .MAR(mar_b), .MDR(mdr_b), .ADDR(addr_b), .Data_to_SRAM(dts_b),
        .CE_N(ce_n_b), .UB_N(ub_n_b), .LB_N(lb_n_b), .OE_N(oe_n_b), .WE_N(we_n_b),
        .busy(busy_b), .done(done_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t = 0 when idle; otherwise 1..W during the strobe window, W+1 for done.
    int           m_t   [2] = '{0, 0};
    logic [W-1:0] m_mar [2] = '{16'h0, 16'h0};
    logic [W-1:0] m_mdr [2] = '{16'h0, 16'h0};
    logic         m_op  [2] = '{1'b0, 1'b0};
    bit           chk_en    = 1'b0;

    function automatic int wait_of(input int i);
        return (i == 0) ? WA : WB;
    endfunction

    always @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (Reset) begin
                m_t[i]   = 0;
                m_mar[i] = '0;
                m_mdr[i] = '0;
                m_op[i]  = 1'b0;
            end else if (m_t[i] == 0) begin
                if (LD_MAR) m_mar[i] = BUS;
                if (LD_MDR) m_mdr[i] = BUS;
                if (mem_start) begin
                    m_op[i] = mem_we;
                    m_t[i]  = 1;
                end
            end else begin
                if (m_t[i] == wait_of(i) && !m_op[i]) m_mdr[i] = Data_from_SRAM;
                m_t[i] = (m_t[i] == wait_of(i) + 1) ? 0 : m_t[i] + 1;
            end
        end
    end

    // Packed as {pad, MAR, MDR, ADDR, Data_to_SRAM, CE,UB,LB,OE,WE, busy, done}
    function automatic logic [79:0] model_vec(input int i);
        logic [4:0] s;
        logic       in_access;
        in_access = (m_t[i] >= 1) && (m_t[i] <= wait_of(i));
        s = in_access ? {3'b000, m_op[i], ~m_op[i]} : 5'b11111;
        return {9'b0, m_mar[i], m_mdr[i], m_mar[i], m_mdr[i], s,
                (m_t[i] != 0), (m_t[i] == wait_of(i) + 1)};
    endfunction

    wire [79:0] vec_a = {9'b0, mar_a, mdr_a, addr_a, dts_a,
                         ce_n_a, ub_n_a, lb_n_a, oe_n_a, we_n_a, busy_a, done_a};
    wire [79:0] vec_b = {9'b0, mar_b, mdr_b, addr_b, dts_b,
                         ce_n_b, ub_n_b, lb_n_b, oe_n_b, we_n_b, busy_b, done_b};

    always @(negedge Clk) begin
        if (chk_en) begin
            check($sformatf("model_a @%0t", $time), vec_a, model_vec(0));
            check($sformatf("model_b @%0t", $time), vec_b, model_vec(1));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        LD_MAR    = 1'b0;
        LD_MDR    = 1'b0;
        mem_start = 1'b0;
        mem_we    = 1'b0;
    endtask

    function automatic logic [79:0] strobes_a();
        return 80'({ce_n_a, ub_n_a, lb_n_a, oe_n_a, we_n_a});
    endfunction

    function automatic logic [79:0] strobes_b();
        return 80'({ce_n_b, ub_n_b, lb_n_b, oe_n_b, we_n_b});
    endfunction

    initial begin
        // 1. Reset with every input active
        Reset = 1'b1; BUS = 16'hFFFF; LD_MAR = 1'b1; LD_MDR = 1'b1;
        mem_start = 1'b1; mem_we = 1'b1; Data_from_SRAM = 16'hFFFF;
        cyc(); cyc();
        chk_en = 1'b1;
        check("t1 MAR", 80'(mar_a), 80'(16'h0000));
        check("t1 MDR", 80'(mdr_a), 80'(16'h0000));
        check("t1 strobes", strobes_a(), 80'(5'b11111));
        check("t1 busy/done", 80'({busy_a, done_a}), 80'(2'b00));
        Reset = 1'b0; idle_inputs(); Data_from_SRAM = 16'h0000;
        cyc();

        // 2. Write 0xBEEF to 0x3000
        BUS = 16'h3000; LD_MAR = 1'b1; cyc();
        LD_MAR = 1'b0; BUS = 16'hBEEF; LD_MDR = 1'b1; cyc();
        LD_MDR = 1'b0; mem_start = 1'b1; mem_we = 1'b1; cyc();
        mem_start = 1'b0; mem_we = 1'b0;   // later mem_we change must not matter
        check("t2 strobes c1", strobes_a(), 80'(5'b00010));
        check("t2 ADDR", 80'(addr_a), 80'(16'h3000));
        check("t2 Data_to_SRAM", 80'(dts_a), 80'(16'hBEEF));
        check("t2 busy/done c1", 80'({busy_a, done_a}), 80'(2'b10));
        cyc();
        check("t2 strobes c2", strobes_a(), 80'(5'b00010));
        cyc();
        check("t2 strobes done", strobes_a(), 80'(5'b11111));
        check("t2 busy/done c3", 80'({busy_a, done_a}), 80'(2'b11));
        cyc();
        check("t2 busy/done idle", 80'({busy_a, done_a}), 80'(2'b00));

        // 3. Read from 0x0042; LD_MDR on the capture edge loses
        BUS = 16'h0042; LD_MAR = 1'b1; cyc();
        LD_MAR = 1'b0; mem_start = 1'b1; mem_we = 1'b0; Data_from_SRAM = 16'h1234; cyc();
        mem_start = 1'b0;
        check("t3 OE_N c1", 80'(oe_n_a), 80'(1'b0));
        cyc();
        check("t3 OE_N c2", 80'(oe_n_a), 80'(1'b0));
        BUS = 16'hFFFF; LD_MDR = 1'b1; cyc();
        LD_MDR = 1'b0; Data_from_SRAM = 16'h0000;
        check("t3 MDR at done", 80'(mdr_a), 80'(16'h1234));
        check("t3 done", 80'(done_a), 80'(1'b1));
        cyc();
        check("t3 MDR idle", 80'(mdr_a), 80'(16'h1234));

        // 4. Busy lockout during a write
        mem_start = 1'b1; mem_we = 1'b1; cyc();
        BUS = 16'h5555; LD_MAR = 1'b1; LD_MDR = 1'b1; mem_start = 1'b1; cyc();
        check("t4 MAR locked", 80'(mar_a), 80'(16'h0042));
        check("t4 MDR locked", 80'(mdr_a), 80'(16'h1234));
        idle_inputs(); cyc();
        check("t4 done once", 80'(done_a), 80'(1'b1));
        cyc();
        check("t4 no 2nd access", 80'({busy_a, done_a}), 80'(2'b00));
        cyc();
        check("t4 still idle", 80'({busy_a, done_a}), 80'(2'b00));

        // 5. LD_MAR together with mem_start
        BUS = 16'h00AA; LD_MAR = 1'b1; mem_start = 1'b1; mem_we = 1'b0;
        Data_from_SRAM = 16'h7777; cyc();
        idle_inputs();
        check("t5 ADDR c1", 80'(addr_a), 80'(16'h00AA));
        cyc();
        check("t5 ADDR c2", 80'(addr_a), 80'(16'h00AA));
        cyc(); cyc();
        check("t5 MDR", 80'(mdr_a), 80'(16'h7777));

        // 6. Reset in first ACCESS cycle of a read, then WAIT_CYCLES=1 access
        mem_start = 1'b1; mem_we = 1'b0; Data_from_SRAM = 16'h9999; cyc();
        mem_start = 1'b0; Reset = 1'b1; cyc();
        check("t6 strobes after reset", strobes_a(), 80'(5'b11111));
        check("t6 busy/done after reset", 80'({busy_a, done_a}), 80'(2'b00));
        check("t6 MDR after reset", 80'(mdr_a), 80'(16'h0000));
        Reset = 1'b0; cyc();
        check("t6 no done", 80'({done_a, done_b}), 80'(2'b00));
        mem_start = 1'b1; mem_we = 1'b0; Data_from_SRAM = 16'h4321; cyc();
        mem_start = 1'b0;
        check("t6b strobes c1", strobes_b(), 80'(5'b00001));
        check("t6b busy/done c1", 80'({busy_b, done_b}), 80'(2'b10));
        cyc();
        check("t6b done k+2", 80'({busy_b, done_b}), 80'(2'b11));
        check("t6b MDR", 80'(mdr_b), 80'(16'h4321));
        check("t6b strobes done", strobes_b(), 80'(5'b11111));
        cyc();
        check("t6b idle k+3", 80'({busy_b, done_b}), 80'(2'b00));
        Data_from_SRAM = 16'h0000;
        cyc(); cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
